// File: rtl/pwm_sched_pkg.sv
// Shared definitions for the PWM scheduler: FSM encoding and default widths.
package pwm_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    SWITCH = 2'd2
  } state_t;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_CNT_W   = 16;
  localparam int DEF_DWELL_W = 8;

endpackage

// File: rtl/pwm_sched_core.sv
// PWM period counter with wrap detect and duty compare.
module pwm_sched_core
  import pwm_sched_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             run,
  input  logic             run_d,
  input  logic [CNT_W-1:0] period_q,
  input  logic [CNT_W-1:0] duty_d,
  output logic [CNT_W-1:0] cnt,
  output logic             at_end,
  output logic             pwm
);

  logic [CNT_W-1:0] cnt_d;

  assign at_end = (cnt == period_q);

  always_comb begin
    cnt_d = cnt + CNT_W'(1);
    if (!run || !run_d || at_end) cnt_d = '0;
  end

  // pwm is registered from the next count and next duty so it lines up with cnt
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt <= '0;
      pwm <= 1'b0;
    end else begin
      cnt <= cnt_d;
      pwm <= run_d && (cnt_d < duty_d);
    end
  end

endmodule

// File: rtl/pwm_sched.sv
// Round-robin scheduler sharing one PWM output among NUM_REQ requesters.
// Optional duty fade-in is compiled in with PWM_SCHED_FADE_EN.
module pwm_sched
  import pwm_sched_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int DWELL_W   = DEF_DWELL_W,
  parameter int FADE_STEP = 16
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] req_duty,
  input  logic [CNT_W-1:0]         period,
  input  logic [DWELL_W-1:0]       dwell,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     busy,
  output logic                     period_end,
  output logic                     pwm
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t               state, state_d;
  logic [IDX_W-1:0]     owner, owner_d, rr_ptr, rr_ptr_d, win_idx;
  logic                 win_found, at_end, last_period;
  logic [CNT_W-1:0]     duty_q, duty_d, period_q, period_d, cnt, target, win_duty;
  logic [DWELL_W-1:0]   dwell_q, dwell_q_d, dwell_cnt, dwell_cnt_d;
  logic [NUM_REQ-1:0]   grant_d;

`ifdef PWM_SCHED_FADE_EN
  function automatic logic [CNT_W-1:0] entry_duty(input logic [CNT_W-1:0] tgt);
    return '0;
  endfunction

  function automatic logic [CNT_W-1:0] step_duty(input logic [CNT_W-1:0] cur,
                                                 input logic [CNT_W-1:0] tgt);
    logic [CNT_W:0]   sum;
    logic [CNT_W-1:0] sat;
    if (tgt <= cur) return tgt;
    sum = {1'b0, cur} + (CNT_W+1)'(FADE_STEP);
    sat = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    return (sat < tgt) ? sat : tgt;
  endfunction
`else
  function automatic logic [CNT_W-1:0] entry_duty(input logic [CNT_W-1:0] tgt);
    return tgt;
  endfunction

  function automatic logic [CNT_W-1:0] step_duty(input logic [CNT_W-1:0] cur,
                                                 input logic [CNT_W-1:0] tgt);
    logic unused;
    unused = ^cur;
    return tgt;
  endfunction
`endif

  // Round-robin search: descending loop so the smallest offset from rr_ptr wins
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[(int'(rr_ptr) + i) % NUM_REQ]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
      end
    end
  end

  assign win_duty    = req_duty[int'(win_idx)*CNT_W +: CNT_W];
  assign target      = req_duty[int'(owner)*CNT_W +: CNT_W];
  assign period_end  = (state == RUN) && at_end;
  assign busy        = (state == RUN);
  assign last_period = (dwell_cnt == dwell_q - DWELL_W'(1));

  always_comb begin
    state_d     = state;
    owner_d     = owner;
    rr_ptr_d    = rr_ptr;
    duty_d      = duty_q;
    period_d    = period_q;
    dwell_q_d   = dwell_q;
    dwell_cnt_d = dwell_cnt;
    unique case (state)
      RUN: begin
        if (period_end) begin
          if (last_period || !req[owner]) begin
            state_d  = SWITCH;
            rr_ptr_d = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);
          end else begin
            dwell_cnt_d = dwell_cnt + DWELL_W'(1);
            duty_d      = step_duty(duty_q, target);
            period_d    = period;
          end
        end
      end
      default: begin
        state_d = IDLE;
        if (win_found) begin
          state_d     = RUN;
          owner_d     = win_idx;
          duty_d      = entry_duty(win_duty);
          period_d    = period;
          dwell_q_d   = (dwell == '0) ? DWELL_W'(1) : dwell;
          dwell_cnt_d = '0;
        end
      end
    endcase
    grant_d = '0;
    if (state_d == RUN) grant_d[owner_d] = 1'b1;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      duty_q    <= '0;
      period_q  <= '0;
      dwell_q   <= DWELL_W'(1);
      dwell_cnt <= '0;
      grant     <= '0;
    end else begin
      state     <= state_d;
      owner     <= owner_d;
      rr_ptr    <= rr_ptr_d;
      duty_q    <= duty_d;
      period_q  <= period_d;
      dwell_q   <= dwell_q_d;
      dwell_cnt <= dwell_cnt_d;
      grant     <= grant_d;
    end
  end

  pwm_sched_core #(.CNT_W(CNT_W)) u_core (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .run      (state == RUN),
    .run_d    (state_d == RUN),
    .period_q (period_q),
    .duty_d   (duty_d),
    .cnt      (cnt),
    .at_end   (at_end),
    .pwm      (pwm)
  );

endmodule

// File: doc/pwm_sched.md
PWM_SCHED -- requirements
Module: pwm_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing the PWM output.
REQ-002 SHALL have parameter CNT_W, default 16: width of the period counter, duty and period values.
REQ-003 SHALL have parameter DWELL_W, default 8: width of the dwell count, in PWM periods.
REQ-004 SHALL have parameter FADE_STEP, default 16: per-period duty increment, used only when fade is compiled in.
REQ-005 SHALL have port sys_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port sys_rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port req, input, NUM_REQ bits: per-requester request level.
REQ-008 SHALL have port req_duty, input, NUM_REQ*CNT_W bits: per-requester target duty; requester i occupies bits [i*CNT_W +: CNT_W].
REQ-009 SHALL have port period, input, CNT_W bits: PWM terminal count; one PWM period is period+1 cycles.
REQ-010 SHALL have port dwell, input, DWELL_W bits: PWM periods per grant; a value of 0 is treated as 1.
REQ-011 SHALL have port grant, output, NUM_REQ bits: one-hot owner of the PWM output, or all zero.
REQ-012 SHALL have port busy, output, 1 bit: high while in RUN.
REQ-013 SHALL have port period_end, output, 1 bit: one-cycle pulse on the last cycle of each PWM period.
REQ-014 SHALL have port pwm, output, 1 bit: the shared PWM output.

Function
REQ-015 SHALL implement the FSM states IDLE, RUN and SWITCH.
REQ-016 IDLE: grant=0, pwm=0; when any req bit is sampled high, go to RUN on the next edge and grant the round-robin winner.
REQ-017 Arbitration SHALL be round-robin: the search starts at rr_ptr and wraps modulo NUM_REQ; the lowest index at or after rr_ptr wins.
REQ-018 On entry to RUN: cnt=0, dwell_cnt=0; duty_q, period_q and dwell_q are loaded from the winner's req_duty, period and dwell.
REQ-019 RUN: cnt counts up 0..period_q, then wraps to 0; pwm = (cnt < duty_q).
REQ-020 Duty boundaries: duty_q=0 gives pwm constantly low; duty_q > period_q gives pwm constantly high.
REQ-021 period_end SHALL be 1 exactly when in RUN and cnt==period_q.
REQ-022 At period_end, if dwell_cnt==dwell_q-1 or the owner's req is low, go to SWITCH.
REQ-023 At period_end otherwise: dwell_cnt increments, and duty_q/period_q reload from the live inputs. Inputs are never applied mid-period, so there are no glitches.
REQ-024 Requester drop: a req that falls mid-period keeps its grant until that period_end (the period is completed, not truncated).
REQ-025 SWITCH lasts one cycle: grant=0, pwm=0, rr_ptr=(owner+1) mod NUM_REQ.
REQ-026 SWITCH exit: arbitrate using the new rr_ptr; go to RUN if any req is high, else to IDLE. There is always a one-cycle gap between grants.
REQ-027 A sole requester re-wins after SWITCH and continues with a fresh dwell.
REQ-028 busy SHALL be 1 only in RUN.
REQ-029 Output latencies: grant and pwm are registered outputs; period_end is combinational from registers.

Reset
REQ-030 With sys_rst high at an edge, the next state SHALL be: state=IDLE, grant=0, pwm=0, busy=0, period_end=0, cnt=0, dwell_cnt=0, duty_q=0, rr_ptr=0.
REQ-031 Reset asserted mid-RUN SHALL abort the current period immediately, with no completion.

Configuration
REQ-032 The macro PWM_SCHED_FADE_EN SHALL control fade.
REQ-033 With PWM_SCHED_FADE_EN defined:
- on entry to RUN, duty_q=0;
- at each non-final period_end, duty_q = min(duty_q+FADE_STEP, target);
- if the target falls below duty_q, duty_q = target immediately;
- the addition saturates and never wraps past 2^CNT_W-1.
REQ-034 Without PWM_SCHED_FADE_EN, duty_q SHALL jump directly to target per REQ-018/REQ-023; the fade logic is not synthesized.

Structure
REQ-035 The package pwm_sched_pkg SHALL hold the state encoding (IDLE/RUN/SWITCH) and the default NUM_REQ, CNT_W and DWELL_W constants.
REQ-036 The counter/compare datapath (cnt, wrap, pwm compare) SHALL be the sub-module pwm_sched_core. The FSM, arbiter and duty/fade logic stay in pwm_sched.

Verification
REQ-037 Single requester: req=0001, duty=3, period=9, dwell=2 -> grant=0001 one cycle after req; pwm high 3 of every 10 cycles; period_end every 10 cycles; a one-cycle SWITCH gap after 2 periods, then re-grant.
REQ-038 Round-robin: req=1111, dwell=1 -> grant sequence 0001,0010,0100,1000,0001, each separated by one zero-grant cycle.
REQ-039 Mid-period drop: req[1] falls at cnt=4, period=9 -> grant[1] holds through cnt=9, then SWITCH; next requester granted, or IDLE if none.
REQ-040 Duty boundaries: duty=0 -> pwm never high; duty=10 with period=9 -> pwm high every RUN cycle; a duty change at cnt=5 takes effect only at the next period start.
REQ-041 Reset mid-RUN: sys_rst pulsed at cnt=6 -> next cycle grant=0, pwm=0, busy=0; after release, req=0100 is granted with rr_ptr=0.
REQ-042 Fade (PWM_SCHED_FADE_EN, FADE_STEP=16, target=40, period=99, dwell=5) -> duty_q per period 0,16,32,40,40.
